// File: rtl/mux4_pkg.sv
// Shared widths and state encoding for the round-robin mux feeder.
package mux4_pkg;
  localparam int NCH    = 4;
  localparam int SEL_W  = 2;
  localparam int DATA_W = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;
endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: first requesting channel after last_ch, modulo 4.
module rr_pick4
  import mux4_pkg::*;
(
  input  logic [NCH-1:0]   req,
  input  logic [SEL_W-1:0] last_ch,
  output logic [SEL_W-1:0] pick,
  output logic             any
);
  logic [SEL_W-1:0] idx;

  // Walk farthest-to-nearest so the nearest requester after last_ch is the final write.
  always_comb begin
    pick = '0;
    idx  = '0;
    for (int k = NCH; k >= 1; k--) begin
      idx = last_ch + SEL_W'(k);
      if (req[idx]) pick = idx;
    end
  end

  assign any = |req;
endmodule

// File: rtl/mux4_rr_feeder.sv
// Round-robin burst arbiter driving an external 8-bit 4:1 mux select, with a registered valid/ready output.
module mux4_rr_feeder
  import mux4_pkg::*;
#(
  parameter int BURST = 4,
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    req,
  output logic [NCH-1:0]    gnt,
  output logic [SEL_W-1:0]  sel,
  input  logic [DATA_W-1:0] mux_out,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);
  state_e              state_q;
  logic [SEL_W-1:0]    cur_ch_q;
  logic [SEL_W-1:0]    last_ch_q;
  logic [SEL_W-1:0]    sel_q;
  logic [CNT_W-1:0]    burst_cnt_q;
  logic [CNT_W-1:0]    burst_cnt_d;
  logic [DATA_W-1:0]   out_data_q;
  logic                out_valid_q;
  logic                busy_q;

  logic                slot_free;
  logic                capture;
  logic                burst_end;
  logic [SEL_W-1:0]    pick;
  logic                any;

  rr_pick4 u_pick (
    .req     (req),
    .last_ch (last_ch_q),
    .pick    (pick),
    .any     (any)
  );

  assign slot_free   = !out_valid_q || out_ready;
  assign capture     = (state_q == ACTIVE) && req[cur_ch_q] && slot_free;
  assign burst_end   = (burst_cnt_q == CNT_W'(BURST - 1));
  assign burst_cnt_d = burst_cnt_q + 1'b1;

  // gnt is the capture strobe itself so the source advances on the same edge the byte is taken.
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_gnt
      assign gnt[gi] = capture && (cur_ch_q == SEL_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cur_ch_q    <= '0;
      last_ch_q   <= SEL_W'(NCH - 1);
      sel_q       <= '0;
      burst_cnt_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      if (capture) begin
        out_data_q  <= mux_out;
        out_valid_q <= 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (any) begin
            cur_ch_q    <= pick;
            sel_q       <= pick;
            burst_cnt_q <= '0;
            state_q     <= ACTIVE;
            busy_q      <= 1'b1;
          end
        end
        ACTIVE: begin
          if (capture) burst_cnt_q <= burst_cnt_d;
          // Dropping req also hands priority away, so a flaky source cannot hog the arbiter.
          if ((capture && burst_end) || !req[cur_ch_q]) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            last_ch_q <= cur_ch_q;
          end
        end
      endcase
    end
  end

  assign sel       = sel_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_mux4_rr_feeder.sv
// Random + directed check of mux4_rr_feeder (BURST=4 and BURST=1 instances) against a behavioural model.
module tb_mux4_rr_feeder;
  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       out_ready;
  logic [7:0] d [4];
  bit         chk_en;

  logic [3:0] gnt_a  [2];
  logic [1:0] sel_a  [2];
  logic [7:0] mux_a  [2];
  logic [7:0] odat_a [2];
  logic       ov_a   [2];
  logic       busy_a [2];

  int checks   = 0;
  int failures = 0;

  // The mux itself lives outside the block; model it here.
  assign mux_a[0] = d[sel_a[0]];
  assign mux_a[1] = d[sel_a[1]];

  mux4_rr_feeder #(.BURST(4), .CNT_W(4)) u_b4 (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt_a[0]), .sel(sel_a[0]),
    .mux_out(mux_a[0]), .out_data(odat_a[0]), .out_valid(ov_a[0]),
    .out_ready(out_ready), .busy(busy_a[0])
  );

  mux4_rr_feeder #(.BURST(1), .CNT_W(1)) u_b1 (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt_a[1]), .sel(sel_a[1]),
    .mux_out(mux_a[1]), .out_data(odat_a[1]), .out_valid(ov_a[1]),
    .out_ready(out_ready), .busy(busy_a[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: who owns the mux, how many bytes it has taken, and the output holding slot.
  typedef struct {
    int         owner;
    int         taken;
    int         last;
    logic [1:0] sel;
    logic [7:0] data;
    bit         v;
  } mstate_t;

  mstate_t m [2];

  function automatic mstate_t m_init();
    mstate_t s;
    s.owner = -1; s.taken = 0; s.last = 3; s.sel = 2'd0; s.data = 8'h00; s.v = 1'b0;
    return s;
  endfunction

  function automatic int burst_of(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  function automatic mstate_t mstep(input mstate_t s, input int b, input logic [3:0] r,
                                    input bit rd, input logic [7:0] byte_in);
    mstate_t n;
    bit      found;
    int      c;
    n = s;
    found = 1'b0;
    if (s.owner < 0) begin
      if (rd) n.v = 1'b0;
      for (int j = 1; j <= 4; j++) begin
        c = (s.last + j) % 4;
        if (!found && r[c]) begin
          found   = 1'b1;
          n.owner = c;
          n.sel   = 2'(c);
          n.taken = 0;
        end
      end
    end else if (r[s.owner] && (!s.v || rd)) begin
      n.data  = byte_in;
      n.v     = 1'b1;
      n.taken = s.taken + 1;
      if (n.taken == b) begin
        n.last  = s.owner;
        n.owner = -1;
      end
    end else begin
      if (rd) n.v = 1'b0;
      if (!r[s.owner]) begin
        n.last  = s.owner;
        n.owner = -1;
      end
    end
    return n;
  endfunction

  function automatic logic [3:0] exp_gnt(input mstate_t s, input logic [3:0] r, input bit rd);
    if (s.owner >= 0 && r[s.owner] && (!s.v || rd)) return 4'b0001 << s.owner;
    return 4'b0000;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) m[k] <= m_init();
      else        m[k] <= mstep(m[k], burst_of(k), req, out_ready, d[m[k].owner & 3]);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("model_gnt%0d", k),   32'(gnt_a[k]),  32'(exp_gnt(m[k], req, out_ready)));
        chk($sformatf("model_sel%0d", k),   32'(sel_a[k]),  32'(m[k].sel));
        chk($sformatf("model_data%0d", k),  32'(odat_a[k]), 32'(m[k].data));
        chk($sformatf("model_valid%0d", k), 32'(ov_a[k]),   32'(m[k].v));
        chk($sformatf("model_busy%0d", k),  32'(busy_a[k]), 32'(m[k].owner >= 0));
      end
    end
  end

  // Called at a falling edge; leaves reset released at a falling edge with the given inputs.
  task automatic reset_to(input logic [3:0] r, input bit rd);
    chk_en = 1'b0;
    rst_n  = 1'b0;
    @(negedge clk);
    req       = r;
    out_ready = rd;
    rst_n     = 1'b1;
    #1 chk_en = 1'b1;
  endtask

  initial begin
    logic [3:0] eg;
    int         ch;
    chk_en    = 1'b0;
    rst_n     = 1'b0;
    req       = 4'b0000;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) d[i] = 8'h00;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_sel",   32'(sel_a[k]),  32'd0);
      chk("rst_gnt",   32'(gnt_a[k]),  32'd0);
      chk("rst_data",  32'(odat_a[k]), 32'h00);
      chk("rst_valid", 32'(ov_a[k]),   32'd0);
      chk("rst_busy",  32'(busy_a[k]), 32'd0);
    end

    // First grant latency: arbitration cycle, then capture.
    d[0] = 8'hA5;
    reset_to(4'b0001, 1'b1);
    @(negedge clk);
    chk("lat_sel",   32'(sel_a[0]), 32'd0);
    chk("lat_gnt",   32'(gnt_a[0]), 32'b0001);
    chk("lat_valid0", 32'(ov_a[0]), 32'd0);
    @(negedge clk);
    chk("lat_data",  32'(odat_a[0]), 32'hA5);
    chk("lat_valid1", 32'(ov_a[0]),  32'd1);

    // Full rotation with all channels requesting, including the wrap back to channel 0.
    reset_to(4'b1111, 1'b1);
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk);
      eg = (i % 5 == 4) ? 4'b0000 : (4'b0001 << ((i / 5) % 4));
      chk("rot_b4", 32'(gnt_a[0]), 32'(eg));
      eg = (i % 2 == 1) ? 4'b0000 : (4'b0001 << ((i / 2) % 4));
      chk("rot_b1", 32'(gnt_a[1]), 32'(eg));
    end

    // BURST=1 with only channel 3: re-granted every second cycle.
    reset_to(4'b1000, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      eg = (i % 2 == 0) ? 4'b1000 : 4'b0000;
      chk("solo3_gnt", 32'(gnt_a[1]), 32'(eg));
      chk("solo3_sel", 32'(sel_a[1]), 32'd3);
    end

    // Backpressure on channel 2: no grant, no count, data frozen.
    d[2] = 8'h11;
    reset_to(4'b0100, 1'b1);
    @(negedge clk);
    chk("stall_gnt_first", 32'(gnt_a[0]), 32'b0100);
    @(posedge clk); #1;
    out_ready = 1'b0;
    d[2] = 8'h22;
    repeat (3) begin
      @(negedge clk);
      chk("stall_gnt",  32'(gnt_a[0]),  32'd0);
      chk("stall_data", 32'(odat_a[0]), 32'h11);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("resume_gnt", 32'(gnt_a[0]), 32'b0100);
    @(negedge clk);
    chk("resume_data", 32'(odat_a[0]), 32'h22);
    chk("resume_gnt3", 32'(gnt_a[0]),  32'b0100);
    @(negedge clk);
    chk("resume_gnt4", 32'(gnt_a[0]), 32'b0100);
    @(negedge clk);
    chk("burst_done_gnt",  32'(gnt_a[0]),  32'd0);
    chk("burst_done_busy", 32'(busy_a[0]), 32'd0);

    // Channel 1 drops req mid-burst and loses priority to channel 0.
    reset_to(4'b0010, 1'b1);
    @(negedge clk);
    chk("drop_gnt_a", 32'(gnt_a[0]), 32'b0010);
    @(negedge clk);
    chk("drop_gnt_b", 32'(gnt_a[0]), 32'b0010);
    @(posedge clk); #1;
    req = 4'b0001;
    @(negedge clk);
    chk("drop_nogrant", 32'(gnt_a[0]),  32'd0);
    chk("drop_busy",    32'(busy_a[0]), 32'd1);
    @(posedge clk); #1;
    req = 4'b0011;
    @(negedge clk);
    chk("drop_idle", 32'(busy_a[0]), 32'd0);
    @(negedge clk);
    chk("drop_next_ch0", 32'(gnt_a[0]), 32'b0001);

    // Randomised traffic with a reset dropped in the middle.
    reset_to(4'b0000, 1'b1);
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      if (n == 1500) begin
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
          chk("midrst_valid", 32'(ov_a[k]),   32'd0);
          chk("midrst_data",  32'(odat_a[k]), 32'h00);
          chk("midrst_sel",   32'(sel_a[k]),  32'd0);
          chk("midrst_gnt",   32'(gnt_a[k]),  32'd0);
        end
        req       = 4'b1111;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_first_b4", 32'(gnt_a[0]), 32'b0001);
        chk("midrst_first_b1", 32'(gnt_a[1]), 32'b0001);
      end else begin
        for (int b = 0; b < 4; b++) begin
          if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
          d[b] = 8'($urandom);
        end
        out_ready = ($urandom_range(0, 3) != 0);
        ch = $urandom_range(0, 30);
        if (ch == 0) out_ready = 1'b0;
      end
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mux4_rr_feeder.md
Name: mux4_rr_feeder

Overview:
- Sequential control stage wrapped around the 8-bit 4:1 data mux.
- Arbitrates four byte-wide request channels round-robin and drives the mux 2-bit select.
- Registers the selected byte returned from the mux and presents it downstream with a valid/ready handshake.
- Grants bursts of up to BURST bytes per channel before rotating, so one channel cannot starve the others.

Parameters:
- BURST, 4, maximum bytes taken from one channel per grant (1..16).
- CNT_W, 4, burst counter width; must satisfy 2^CNT_W >= BURST.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  per-channel "byte available"; bit i means channel i's byte is present on mux input d(i+1).
- gnt  output  4  one-hot, one-cycle pulse: channel i's byte was captured this cycle and the channel must advance.
- sel  output  2  select to mux; 0..3 selects channel 0..3.
- mux_out  input  8  selected byte returned combinationally from the mux.
- out_data  output  8  registered byte to downstream.
- out_valid  output  1  out_data holds an unconsumed byte.
- out_ready  input  1  downstream accepts out_data this cycle.
- busy  output  1  high whenever state is ACTIVE.

Behaviour:
- Reset values (async on rst_n low):
  - outputs: sel=0, gnt=0, out_data=0x00, out_valid=0, busy=0.
  - internal: state=IDLE, last_ch=3 (so channel 0 wins first), burst_cnt=0.
- Slot-free definition: slot_free = !out_valid || out_ready.
- States:
  - IDLE:
    - No channel granted; gnt=0.
    - If req != 0, pick the first set bit searching last_ch+1, last_ch+2, ... modulo 4.
    - Register the pick into cur_ch and sel, clear burst_cnt, go to ACTIVE.
    - If req == 0, stay in IDLE; sel holds its last value.
  - ACTIVE:
    - sel = cur_ch, held stable for the whole state.
    - Capture when req[cur_ch] && slot_free:
      - out_data <= mux_out, out_valid <= 1.
      - gnt[cur_ch] = 1 for exactly this cycle.
      - burst_cnt increments.
    - Exit to IDLE with last_ch <= cur_ch when either:
      - a capture occurs with burst_cnt == BURST-1, or
      - req[cur_ch] is low (with or without an earlier capture).
    - While req[cur_ch] is high and !slot_free, stall in ACTIVE with no gnt and no count.
- Output handshake:
  - out_valid falls when out_ready=1 and no capture occurs in the same cycle.
  - Capture and out_ready in the same cycle: out_data is replaced and out_valid stays 1 (back-to-back throughput of 1 byte/cycle).
  - out_data is never changed while out_valid=1 && out_ready=0.
- Latency:
  - req rising from IDLE to first gnt/capture: 2 clocks (arbitration cycle, then capture cycle).
  - out_valid rises on the capture edge.
  - Rotation costs exactly one IDLE bubble between bursts.
- Boundary conditions:
  - BURST=1: strict per-byte rotation, one IDLE cycle between bytes.
  - Round-robin wrap: last_ch=3 searches 0,1,2,3 in that order.
  - Only the previous channel requesting: it is re-granted after one IDLE cycle (no dead lock-out).
  - req[cur_ch] dropping in ACTIVE: exit without gnt; last_ch still updates, so the channel loses priority.
  - req bits of non-selected channels changing during ACTIVE: ignored until the next IDLE.
  - gnt is always one-hot or zero and only asserts for cur_ch.
- Reset mid-operation: state and registers clear immediately; a pending out_data byte is discarded; no gnt is emitted on the reset cycle or the cycle after release.

Decomposition:
- Shared package mux4_pkg:
  - NCH=4, SEL_W=2, DATA_W=8.
  - State enum: IDLE=1'b0, ACTIVE=1'b1.
- One natural sub-module: rr_pick4.
  - Combinational; inputs req[3:0] and last_ch[1:0]; outputs pick[1:0] and any.
  - Instantiated once for the IDLE arbitration.
- The 8-bit 4:1 mux stays a separate module, instantiated beside this block at the top level.

Test Plan:
- Reset then req=4'b0001, out_ready=1, d1=0xA5 -> sel=0 on cycle 1, gnt=0001 and out_data=0xA5 with out_valid=1 on cycle 2.
- req=4'b1111 held, BURST=4, out_ready=1 -> exactly 4 gnt pulses to channel 0, one IDLE cycle, 4 to channel 1, then 2, then 3, then wraps to 0.
- Channel 2 active, out_ready=0 for 3 cycles -> no gnt and no burst_cnt change; out_data frozen at the first captured value; capture resumes the cycle out_ready=1.
- req=4'b1000 only, BURST=1 -> gnt[3] pulses every 2nd cycle; sel stays 3.
- Channel 1 active, req[1] drops after 2 captures (BURST=4) -> IDLE next cycle; with req=4'b0011 the next grant goes to channel 0, not channel 1.
- Assert rst_n=0 mid-burst with out_valid=1 -> out_valid=0, out_data=0x00, sel=0 immediately; after release the first grant goes to channel 0.
